// File: rtl/regfile_arbiter_if.sv
// Requester-side and regfile-side signals of the regfile arbiter.
// The arbiter takes the slave view; the requesters and regfile take the master view.
interface regfile_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          CoreReq;
    logic          CoreWrite;
    logic [AW-1:0] CoreRA1;
    logic [AW-1:0] CoreRA2;
    logic [AW-1:0] CoreWA;
    logic [DW-1:0] CoreWD;
    logic          CoreGnt;
    logic          CoreRspValid;
    logic [DW-1:0] CoreRD1;
    logic [DW-1:0] CoreRD2;

    logic          DbgReq;
    logic          DbgWrite;
    logic [AW-1:0] DbgRA;
    logic [AW-1:0] DbgWA;
    logic [DW-1:0] DbgWD;
    logic          DbgGnt;
    logic          DbgRspValid;
    logic [DW-1:0] DbgRD;

    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;

    modport slave (
        input  CoreReq, CoreWrite, CoreRA1, CoreRA2, CoreWA, CoreWD,
        input  DbgReq, DbgWrite, DbgRA, DbgWA, DbgWD,
        input  ReadData1, ReadData2,
        output CoreGnt, CoreRspValid, CoreRD1, CoreRD2,
        output DbgGnt, DbgRspValid, DbgRD,
        output ReadRegister1, ReadRegister2, WriteRegister,
        output WriteData, RegWrite
    );

    modport master (
        output CoreReq, CoreWrite, CoreRA1, CoreRA2, CoreWA, CoreWD,
        output DbgReq, DbgWrite, DbgRA, DbgWA, DbgWD,
        output ReadData1, ReadData2,
        input  CoreGnt, CoreRspValid, CoreRD1, CoreRD2,
        input  DbgGnt, DbgRspValid, DbgRD,
        input  ReadRegister1, ReadRegister2, WriteRegister,
        input  WriteData, RegWrite
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one regfile between the Core control path
// and the debug port: grant, one ISSUE cycle, then a one-cycle response.
module regfile_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input logic              Clk,
    input logic              Reset_n,
    regfile_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_dbg;
    logic          own_dbg;
    logic          wr;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] crd1;
    logic [DW-1:0] crd2;
    logic [DW-1:0] drd;
    logic          accept;
    logic          core_gnt;
    logic          dbg_gnt;

    // Reset gates the grants so nothing is accepted while Reset_n is low.
    always_comb begin
        accept    = Reset_n && (state != ISSUE);
        core_gnt  = accept && bus.CoreReq && (!bus.DbgReq || last_dbg);
        dbg_gnt   = accept && bus.DbgReq && (!bus.CoreReq || !last_dbg);
        state_nxt = IDLE;
        unique case (state)
            IDLE, RESP: state_nxt = (core_gnt || dbg_gnt) ? ISSUE : IDLE;
            ISSUE:      state_nxt = RESP;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            last_dbg <= 1'b1;
            own_dbg  <= 1'b0;
            wr       <= 1'b0;
            ra1      <= '0;
            ra2      <= '0;
            wa       <= '0;
            wd       <= '0;
            crd1     <= '0;
            crd2     <= '0;
            drd      <= '0;
        end else begin
            state <= state_nxt;
            if (core_gnt) begin
                own_dbg  <= 1'b0;
                last_dbg <= 1'b0;
                wr       <= bus.CoreWrite;
                ra1      <= bus.CoreRA1;
                ra2      <= bus.CoreRA2;
                wa       <= bus.CoreWA;
                wd       <= bus.CoreWD;
            end else if (dbg_gnt) begin
                own_dbg  <= 1'b1;
                last_dbg <= 1'b1;
                wr       <= bus.DbgWrite;
                ra1      <= bus.DbgRA;
                ra2      <= bus.DbgRA;
                wa       <= bus.DbgWA;
                wd       <= bus.DbgWD;
            end
            if (state == ISSUE && !wr) begin
                if (own_dbg) begin
                    drd <= bus.ReadData1;
                end else begin
                    crd1 <= bus.ReadData1;
                    crd2 <= bus.ReadData2;
                end
            end
        end
    end

    assign bus.CoreGnt       = core_gnt;
    assign bus.DbgGnt        = dbg_gnt;
    assign bus.CoreRspValid  = (state == RESP) && !own_dbg;
    assign bus.DbgRspValid   = (state == RESP) && own_dbg;
    assign bus.CoreRD1       = crd1;
    assign bus.CoreRD2       = crd2;
    assign bus.DbgRD         = drd;
    assign bus.ReadRegister1 = ra1;
    assign bus.ReadRegister2 = ra2;
    assign bus.WriteRegister = wa;
    assign bus.WriteData     = wd;
    assign bus.RegWrite      = (state == ISSUE) && wr;
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single-write, dual-read `regfile` between two requesters: the multi-cycle CPU control path (Core) and the debug/scan port (Dbg). It accepts one read or write command per grant, arbitrates round-robin on ties, drives the register file ports from registered state, and returns a registered response. The block sits between the control FSM, the debug unit and the `regfile` instance.

## Interface
Parameters:
- `AW`, 5, register address width.
- `DW`, 32, data width.

Ports:
- `Clk`  in  1  clock; all state changes on the posedge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `CoreReq`  in  1  Core command pending; held until `CoreGnt`.
- `CoreWrite`  in  1  1 = write, 0 = read.
- `CoreRA1`, `CoreRA2`  in  AW  read addresses.
- `CoreWA`  in  AW  write address.
- `CoreWD`  in  DW  write data.
- `CoreGnt`  out  1  combinational accept; command is latched on this edge.
- `CoreRspValid`  out  1  one-cycle response pulse.
- `CoreRD1`, `CoreRD2`  out  DW  read results.
- `DbgReq`  in  1  debug command pending; held until `DbgGnt`.
- `DbgWrite`  in  1  1 = write, 0 = read.
- `DbgRA`, `DbgWA`  in  AW  read and write addresses.
- `DbgWD`  in  DW  write data.
- `DbgGnt`  out  1  combinational accept.
- `DbgRspValid`  out  1  one-cycle response pulse.
- `DbgRD`  out  DW  read result (regfile port 1).
- `ReadRegister1`, `ReadRegister2`, `WriteRegister`  out  AW  to `regfile`.
- `WriteData`  out  DW  to `regfile`.
- `RegWrite`  out  1  to `regfile`.
- `ReadData1`, `ReadData2`  in  DW  from `regfile` (combinational read).

## Operation
FSM states: IDLE, ISSUE, RESP.

Accept:
- A new command can be accepted only in IDLE or RESP.
- If exactly one requester has `Req` high, it is granted.
- If both are high, the requester that was not granted last wins. `Last` resets to Dbg, so Core wins the first tie.
- At most one `Gnt` is high in a cycle.
- On the grant edge the block latches the owner, the write flag, the addresses and the data, updates `Last`, and moves to ISSUE.
- With no request in IDLE or RESP, the next state is IDLE.

ISSUE (exactly one cycle):
- Regfile ports are driven from the latched command.
- For a write, `RegWrite` = 1, so the write commits on the edge that ends ISSUE.
- For a read, `ReadData1`/`ReadData2` are captured on that same edge into the owner's response registers.
- Next state is RESP.

RESP:
- The owner's `RspValid` = 1 for this cycle only. Writes also pulse `RspValid` as a completion ack.
- Read results stay stable until that owner's next read completes. A write never changes the RD registers.
- `RegWrite` = 0. Regfile address/data outputs hold the last command's values.

Dbg read mapping: `ReadRegister1` = `DbgRA`, `ReadRegister2` = `DbgRA`, and `DbgRD` takes `ReadData1`.

Register $0 behaviour is left to `regfile`: a write to 0 is issued normally, and a read of 0 returns whatever the regfile returns.

## Timing
- Latency: `Gnt` in cycle N, ISSUE in N+1, `RspValid` in N+2. Read data is valid together with `RspValid`.
- Throughput: one command every 2 cycles per arbiter, achieved by granting back-to-back from RESP.
- Read-after-write: a read granted in the RESP cycle of a write to the same address returns the new value.
- `Gnt` is a function of state, `Req`s and `Last` only. It never depends on `ReadData*`.
- Requester rule: `Req` and the command fields stay stable until `Gnt`. They may change in the cycle after `Gnt`.
- Reset (asynchronous, any state) forces:
  - state = IDLE, `Last` = Dbg;
  - `RegWrite`, `CoreGnt`, `DbgGnt`, `CoreRspValid`, `DbgRspValid` = 0;
  - `ReadRegister1`, `ReadRegister2`, `WriteRegister` = 0, `WriteData` = 0;
  - `CoreRD1`, `CoreRD2`, `DbgRD` = 0.
- An in-flight write aborted by reset during ISSUE is not committed, because `RegWrite` drops before the edge.
- While `Reset_n` is low, no `Gnt` is issued.

## Test plan
1. Core writes 42 to r2, then Core reads r2/r2. Expect `CoreGnt` at N, `RegWrite` = 1 at N+1, write-ack `CoreRspValid` at N+2. The read is granted at N+2 and returns `CoreRD1` = `CoreRD2` = 42 at N+4.
2. Core and Dbg both request in IDLE after reset. Core is granted first and Dbg is granted in Core's RESP cycle. Repeat with both requests held continuously: grants strictly alternate Core/Dbg/Core/Dbg, and neither side waits more than 2 grants.
3. Dbg writes 323 to r31 while Core reads r31 and r5 in the same cycle (Core is `Last`). Expect Dbg granted first; Core then gets `CoreRD1` = 323 and `CoreRD2` = the prior r5 value.
4. Core write to r0 with data 25, then Dbg read r0. Expect `RegWrite` = 1 with `WriteRegister` = 0 during ISSUE and `DbgRD` = 0. Then a Core read of r3 returns r3 unchanged.
5. Assert `Reset_n` = 0 mid-ISSUE of a write of 99 to r7 (r7 previously 15). Expect `RegWrite` to go 0 immediately and all outputs to reset to 0. After release, a read of r7 returns 15.
6. No requests for 10 cycles. Expect no `Gnt`, no `RspValid`, `RegWrite` = 0, and RD registers holding their last values.
